systolic_array_nxn: RTL and testbench

- Parametrised N×N output-stationary systolic matrix multiplier, C = A×B. It is the next generation of the 2×2 multiplier used in the matrix_multiplier FPGA design.
- The block captures both operand matrices on a start handshake and feeds skewed rows and columns into an N×N grid of MAC PEs.
- It reports completion with a single-cycle done pulse and a held result_valid flag.
- New over the 2×2 block: width, size and signedness are parameters; a start/busy handshake is added; an accumulate mode supports tiled multiplication.

---
 rtl/systolic_array_nxn.sv | 111 +++++++++++
 tb/tb_systolic_array_nxn.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: output-stationary NxN systolic matrix multiplier C = A*B with start/busy/done handshake and accumulate mode
module systolic_array_nxn #(
    parameter int N      = 2,
    parameter int DW     = 2,
    parameter int AW     = 2*DW + $clog2(N),
    parameter bit SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                acc_mode,
    input  logic [N*N*DW-1:0]   a_flat,
    input  logic [N*N*DW-1:0]   b_flat,
    output logic [N*N*AW-1:0]   result_flat,
    output logic                busy,
    output logic                done,
    output logic                result_valid
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SW = $clog2(3*N-2);
    localparam logic [SW-1:0] LAST = SW'(3*N-3);
    state_t state, state_n;
    logic [SW-1:0] step;
    logic accept, last;
    logic [DW-1:0] a_q [N][N];
    logic [DW-1:0] b_q [N][N];
    logic [DW-1:0] h_q [N][N];
    logic [DW-1:0] v_q [N][N];
    logic [DW-1:0] row_in [N][N];
    logic [DW-1:0] col_in [N][N];
    logic [AW-1:0] acc [N][N];

    function automatic logic [AW-1:0] ext(input logic [DW-1:0] x);
        return {{(AW-DW){SIGNED & x[DW-1]}}, x};
    endfunction

    assign accept = start && state != RUN;
    assign last   = state == RUN && step == LAST;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb state_n = state == RUN ? (step == LAST ? DONE : RUN) : (start ? RUN : IDLE);

    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    // Edge feeds are skewed by row/column index so PE(i,j) sees A[i][k] and B[k][j] together
    always_comb begin
        for (int i = 0; i < N; i++) begin
            row_in[i][0] = '0;
            col_in[0][i] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(step) == i + k) row_in[i][0] = a_q[i][k];
                if (int'(step) == i + k) col_in[0][i] = b_q[k][i];
            end
            for (int j = 1; j < N; j++) begin
                row_in[i][j] = h_q[i][j-1];
                col_in[j][i] = v_q[j-1][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                    h_q[i][j] <= '0;
                    v_q[i][j] <= '0;
                    acc[i][j] <= '0;
                end
        end else if (accept) begin
            step <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_q[i][j] <= a_flat[(i*N+j)*DW +: DW];
                    b_q[i][j] <= b_flat[(i*N+j)*DW +: DW];
                    h_q[i][j] <= '0;
                    v_q[i][j] <= '0;
                    acc[i][j] <= acc_mode ? acc[i][j] : '0;
                end
        end else if (state == RUN) begin
            step <= step + 1'b1;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    h_q[i][j] <= row_in[i][j];
                    v_q[i][j] <= col_in[i][j];
                    acc[i][j] <= acc[i][j] + ext(row_in[i][j]) * ext(col_in[i][j]);
                end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) result_valid <= 1'b0;
        else if (last)     result_valid <= 1'b1;
    end

    always_comb begin
        result_flat = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                result_flat[(i*N+j)*AW +: AW] = acc[i][j];
    end
endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb_systolic_array_nxn: scoreboard bench for 2x2 unsigned, 4x4 unsigned and 2x2 signed instances
module tb_systolic_array_nxn;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic [2:0] start, acc_mode, busy, done, rv;
    logic [7:0] a2, b2;
    logic [19:0] r2;
    logic [63:0] a4, b4;
    logic [159:0] r4;
    logic [15:0] as_op, bs_op;
    logic [35:0] rs;
    int checks = 0;
    int errors = 0;
    int m [3][4][4];
    logic [159:0] sb [$];
    logic [159:0] last_exp [3];

    systolic_array_nxn #(.N(2), .DW(2)) u2 (.clk(clk), .rst(rst), .start(start[0]), .acc_mode(acc_mode[0]),
        .a_flat(a2), .b_flat(b2), .result_flat(r2), .busy(busy[0]), .done(done[0]), .result_valid(rv[0]));
    systolic_array_nxn #(.N(4), .DW(4)) u4 (.clk(clk), .rst(rst), .start(start[1]), .acc_mode(acc_mode[1]),
        .a_flat(a4), .b_flat(b4), .result_flat(r4), .busy(busy[1]), .done(done[1]), .result_valid(rv[1]));
    systolic_array_nxn #(.N(2), .DW(4), .SIGNED(1)) us (.clk(clk), .rst(rst), .start(start[2]), .acc_mode(acc_mode[2]),
        .a_flat(as_op), .b_flat(bs_op), .result_flat(rs), .busy(busy[2]), .done(done[2]), .result_valid(rv[2]));

    function automatic int dim(input int sel);
        return sel == 1 ? 4 : 2;
    endfunction

    function automatic int dwid(input int sel);
        return sel == 0 ? 2 : 4;
    endfunction

    function automatic int awid(input int sel);
        return sel == 0 ? 5 : (sel == 1 ? 10 : 9);
    endfunction

    function automatic logic [159:0] res(input int sel);
        return sel == 0 ? {140'b0, r2} : (sel == 1 ? r4 : {124'b0, rs});
    endfunction

    function automatic int sx(input int sel, input int x);
        int w = dwid(sel);
        int u = x & ((1 << w) - 1);
        if (sel == 2 && u >= (1 << (w - 1))) u -= 1 << w;
        return u;
    endfunction

    function automatic logic [63:0] pack_ops(input int sel, input int x[4][4]);
        logic [63:0] v = '0;
        int n = dim(sel);
        int w = dwid(sel);
        int e;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                e = x[i][j];
                for (int t = 0; t < w; t++) v[(i*n+j)*w+t] = e[t];
            end
        return v;
    endfunction

    task automatic set_ops(input int sel, input logic [63:0] va, input logic [63:0] vb);
        if (sel == 0) begin a2 = va[7:0]; b2 = vb[7:0]; end
        else if (sel == 1) begin a4 = va; b4 = vb; end
        else begin as_op = va[15:0]; bs_op = vb[15:0]; end
    endtask

    task automatic model(input int sel, input int a[4][4], input int b[4][4], input bit accm, output logic [159:0] e);
        int n = dim(sel);
        int aw = awid(sel);
        int s;
        e = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                s = accm ? m[sel][i][j] : 0;
                for (int k = 0; k < n; k++) s += sx(sel, a[i][k]) * sx(sel, b[k][j]);
                m[sel][i][j] = s;
                for (int t = 0; t < aw; t++) e[(i*n+j)*aw+t] = s[t];
            end
    endtask

    task automatic run_mult(input int sel, input int a[4][4], input int b[4][4], input bit accm, input int restart_at);
        logic [159:0] e, got;
        int n = dim(sel);
        int cyc = 1;
        int nb = 0;
        model(sel, a, b, accm, e);
        sb.push_back(e);
        @(negedge clk);
        set_ops(sel, pack_ops(sel, a), pack_ops(sel, b));
        acc_mode[sel] = accm;
        start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        set_ops(sel, {$urandom, $urandom}, {$urandom, $urandom});
        while (!done[sel] && cyc < 40) begin
            if (busy[sel]) nb++;
            start[sel] = (cyc == restart_at);
            if (cyc == restart_at) begin
                acc_mode[sel] = 1'b0;
                set_ops(sel, {$urandom, $urandom}, {$urandom, $urandom});
            end
            @(negedge clk);
            cyc++;
        end
        start[sel] = 1'b0;
        e = sb.pop_front();
        got = res(sel);
        checks++;
        if (cyc !== 3*n-1) begin errors++; $display("FAIL done_latency sel=%0d got %0d want %0d", sel, cyc, 3*n-1); end
        checks++;
        if (nb !== 3*n-2) begin errors++; $display("FAIL busy_cycles sel=%0d got %0d want %0d", sel, nb, 3*n-2); end
        checks++;
        if (got !== e) begin errors++; $display("FAIL result sel=%0d got %h want %h", sel, got, e); end
        checks++;
        if (rv[sel] !== 1'b1) begin errors++; $display("FAIL result_valid_at_done sel=%0d got %b want 1", sel, rv[sel]); end
        checks++;
        if (busy[sel] !== 1'b0) begin errors++; $display("FAIL busy_with_done sel=%0d got %b want 0", sel, busy[sel]); end
        last_exp[sel] = e;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = '0;
        acc_mode = '0;
        for (int s = 0; s < 3; s++) set_ops(s, '0, '0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (res(s) !== '0) begin errors++; $display("FAIL reset_result sel=%0d got %h want 0", s, res(s)); end
        end
        checks++;
        if ({busy, done, rv} !== 9'b0) begin errors++; $display("FAIL reset_flags got %b want 0", {busy, done, rv}); end
        rst = 1'b0;
    endtask

    task automatic basic_ops(output int a[4][4], output int b[4][4]);
        a = '{'{1, 2, 0, 0}, '{3, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        b = '{'{2, 1, 0, 0}, '{0, 3, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    endtask

    task automatic test_basic();
        int a[4][4], b[4][4];
        basic_ops(a, b);
        run_mult(0, a, b, 1'b0, 0);
    endtask

    task automatic test_accumulate();
        int a[4][4], b[4][4];
        basic_ops(a, b);
        run_mult(0, a, b, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        int a[4][4], b[4][4];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin a[i][j] = 3; b[i][j] = 3; end
        run_mult(0, a, b, 1'b0, 0);
    endtask

    task automatic test_hold();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done[0] !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done[0]); end
            checks++;
            if (rv[0] !== 1'b1) begin errors++; $display("FAIL result_valid_hold got %b want 1", rv[0]); end
            checks++;
            if (res(0) !== last_exp[0]) begin errors++; $display("FAIL result_hold got %h want %h", res(0), last_exp[0]); end
        end
    endtask

    task automatic test_start_in_run();
        int a[4][4], b[4][4];
        basic_ops(a, b);
        run_mult(0, a, b, 1'b0, 2);
    endtask

    task automatic test_reset_mid_run();
        int a[4][4], b[4][4];
        bit seen = 1'b0;
        basic_ops(a, b);
        @(negedge clk);
        set_ops(0, pack_ops(0, a), pack_ops(0, b));
        acc_mode[0] = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done[0]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", seen); end
        checks++;
        if (r2 !== '0) begin errors++; $display("FAIL abort_result got %h want 0", r2); end
        checks++;
        if (rv[0] !== 1'b0) begin errors++; $display("FAIL abort_result_valid got %b want 0", rv[0]); end
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) m[s][i][j] = 0;
        run_mult(0, a, b, 1'b1, 0);
    endtask

    task automatic test_n4();
        int a[4][4], b[4][4];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin a[i][j] = (i == j) ? 1 : 0; b[i][j] = i*4 + j; end
        run_mult(1, a, b, 1'b0, 0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin a[i][j] = $urandom_range(0, 15); b[i][j] = $urandom_range(0, 15); end
            run_mult(1, a, b, p == 1, 0);
        end
    endtask

    task automatic test_signed();
        int a[4][4], b[4][4];
        a = '{'{-1, 2, 0, 0}, '{3, -4, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        b = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        run_mult(2, a, b, 1'b0, 0);
        checks++;
        if (rs !== {9'h1FC, 9'd3, 9'd2, 9'h1FF}) begin errors++; $display("FAIL signed_identity got %h want %h", rs, {9'h1FC, 9'd3, 9'd2, 9'h1FF}); end
        run_mult(2, a, b, 1'b1, 0);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin a[i][j] = $urandom_range(0, 15); b[i][j] = $urandom_range(0, 15); end
        run_mult(2, a, b, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_back_to_back();
        test_hold();
        test_start_in_run();
        test_reset_mid_run();
        test_n4();
        test_signed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
